// File: rtl/id_stage.sv
// id_stage: decode, operand fetch, RAW scoreboard and branch flush ahead of execute.
// Define ID_FORWARD_EN to bypass write-back data into operand reads and hazard checks.
package id_stage_pkg;
  typedef struct packed {
    logic [31:0] rd_value;
    logic [31:0] rs_value;
    logic [31:0] imm_value;
    logic [3:0]  rd_addr;
    logic [15:0] pc;
    logic [6:0]  opcode;
    logic        inte;
    logic        lgc;
    logic        shift;
    logic        ld;
    logic        st;
    logic        br;
    logic        immf;
    logic        rsv;
    logic        valid;
  } id_ex_t;
endpackage

module id_stage #(
  parameter int REG_COUNT = 16,
  parameter bit IMM_SIGN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [15:0] pc_i,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic        stall_i,
  input  logic        branch_en_i,
  input  logic        wb_en_i,
  input  logic [3:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] rd_value_o,
  output logic [31:0] rs_value_o,
  output logic [31:0] imm_value_o,
  output logic [3:0]  rd_addr_o,
  output logic [15:0] pc_value_o,
  output logic [6:0]  opcode_o,
  output logic        ctrl_inte_o,
  output logic        ctrl_logic_o,
  output logic        ctrl_shift_o,
  output logic        ctrl_ld_o,
  output logic        ctrl_st_o,
  output logic        ctrl_br_o,
  output logic        immf_o,
  output logic        rsv_o,
  output logic        valid_o
);
  import id_stage_pkg::*;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e state_q, state_d;
  id_ex_t out_q, out_d, dec;
  logic [REG_COUNT-1:0] sb_q, sb_d;
  logic [31:0] rf_q [REG_COUNT];
  logic [31:0] rf_d [REG_COUNT];

  logic [2:0]  cls;
  logic [3:0]  rd, rs;
  logic        immf, use_rs, hazard, transfer;
  logic [REG_COUNT-1:0] wb_oh, set_oh, byp_oh, busy;

  assign cls  = inst_i[31:29];
  assign rd   = inst_i[24:21];
  assign rs   = inst_i[20:17];
  assign immf = inst_i[16];

  assign wb_oh = wb_en_i ? (REG_COUNT'(1) << wb_addr_i) : '0;

`ifdef ID_FORWARD_EN
  assign byp_oh = wb_oh;
`else
  assign byp_oh = '0;
`endif

  always_comb begin
    dec           = '0;
    dec.rd_addr   = rd;
    dec.pc        = pc_i;
    dec.opcode    = inst_i[31:25];
    dec.immf      = immf;
    dec.imm_value = IMM_SIGN ? {{16{inst_i[15]}}, inst_i[15:0]}
                             : {16'h0, inst_i[15:0]};
    dec.rd_value  = rf_q[rd];
    dec.rs_value  = rf_q[rs];
    if (byp_oh[rd]) dec.rd_value = wb_data_i;
    if (byp_oh[rs]) dec.rs_value = wb_data_i;
    unique case (1'b1)
      cls == 3'd0:      dec.inte  = 1'b1;
      cls == 3'd1:      dec.lgc   = 1'b1;
      cls == 3'd2:      dec.shift = 1'b1;
      cls == 3'd3:      dec.ld    = 1'b1;
      cls == 3'd4:      dec.st    = 1'b1;
      cls == 3'd5:      dec.br    = 1'b1;
      cls[2:1] == 2'b11: dec.valid = 1'b0;
    endcase
    dec.rsv   = dec.inte | dec.lgc | dec.shift | dec.ld;
    dec.valid = dec.rsv | dec.st | dec.br;
    // Illegal opcodes travel as a plain bubble
    if (!dec.valid) dec = '0;
  end

  assign use_rs = ~immf | (cls == 3'd3) | (cls == 3'd4);
  assign busy   = sb_q & ~byp_oh;
  assign hazard = busy[rd] | (use_rs & busy[rs]);

  assign inst_ready_o = rst & (state_q == RUN) & ~stall_i & ~hazard;
  assign transfer     = inst_valid_i & inst_ready_o & ~branch_en_i;
  assign set_oh       = (transfer & dec.rsv) ? (REG_COUNT'(1) << rd) : '0;

  always_comb begin
    out_d = out_q;
    if (branch_en_i)  out_d = '0;
    else if (transfer) out_d = dec;
    else if (!stall_i) out_d = '0;
  end

  // Set after clear so a same-edge issue keeps the bit pending
  always_comb begin
    sb_d = (sb_q & ~wb_oh) | set_oh;
    if (branch_en_i) sb_d = '0;
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en_i) rf_d[wb_addr_i] = wb_data_i;
  end

  assign state_d = branch_en_i ? FLUSH : RUN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      out_q   <= '0;
      sb_q    <= '0;
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sb_q    <= sb_d;
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign rd_value_o   = out_q.rd_value;
  assign rs_value_o   = out_q.rs_value;
  assign imm_value_o  = out_q.imm_value;
  assign rd_addr_o    = out_q.rd_addr;
  assign pc_value_o   = out_q.pc;
  assign opcode_o     = out_q.opcode;
  assign ctrl_inte_o  = out_q.inte;
  assign ctrl_logic_o = out_q.lgc;
  assign ctrl_shift_o = out_q.shift;
  assign ctrl_ld_o    = out_q.ld;
  assign ctrl_st_o    = out_q.st;
  assign ctrl_br_o    = out_q.br;
  assign immf_o       = out_q.immf;
  assign rsv_o        = out_q.rsv;
  assign valid_o      = out_q.valid;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and random stimulus for id_stage against a
// behavioural decode/scoreboard model with a one-cycle execute write-back model.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [15:0] pc_i;
  logic        inst_valid_i, inst_ready_o, stall_i, branch_en_i;
  logic        wb_en_i;
  logic [3:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic [3:0]  rd_addr_o;
  logic [15:0] pc_value_o;
  logic [6:0]  opcode_o;
  logic ctrl_inte_o, ctrl_logic_o, ctrl_shift_o;
  logic ctrl_ld_o, ctrl_st_o, ctrl_br_o;
  logic immf_o, rsv_o, valid_o;

`ifdef ID_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_stage dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .pc_i(pc_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .stall_i(stall_i), .branch_en_i(branch_en_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .rd_value_o(rd_value_o), .rs_value_o(rs_value_o),
    .imm_value_o(imm_value_o), .rd_addr_o(rd_addr_o),
    .pc_value_o(pc_value_o), .opcode_o(opcode_o),
    .ctrl_inte_o(ctrl_inte_o), .ctrl_logic_o(ctrl_logic_o),
    .ctrl_shift_o(ctrl_shift_o), .ctrl_ld_o(ctrl_ld_o),
    .ctrl_st_o(ctrl_st_o), .ctrl_br_o(ctrl_br_o),
    .immf_o(immf_o), .rsv_o(rsv_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [31:0] m_regs [16];
  bit          m_pend [16];
  bit          m_flush;
  bit          e_valid, e_rsv, e_immf;
  bit [5:0]    e_ctrl;
  logic [31:0] e_rdv, e_rsv_val, e_imm;
  logic [3:0]  e_rd;
  logic [15:0] e_pc;
  logic [6:0]  e_opc;
  bit          n_wb_en;
  logic [3:0]  n_wb_addr;
  logic [31:0] n_wb_data;
  bit          f_en;
  logic [3:0]  f_rd;
  logic [31:0] f_val;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc,
      input logic [3:0] rd, input logic [3:0] rs,
      input logic immf, input logic [15:0] imm);
    return {opc, rd, rs, immf, imm};
  endfunction

  function automatic logic [31:0] rdreg(input logic [3:0] r);
    if (FWD && wb_en_i && wb_addr_i == r) return wb_data_i;
    return m_regs[r];
  endfunction

  function automatic bit blocked(input logic [3:0] r);
    return m_pend[r] && !(FWD && wb_en_i && wb_addr_i == r);
  endfunction

  task automatic cyc(input logic [31:0] inst, input logic [15:0] pc,
                     input bit vld, input bit stl, input bit br,
                     output bit acc);
    int  c;
    bit  legal, rsv, use_rs, hz, ready;
    logic [3:0] rdi, rsi;
    logic [31:0] rdv, rsv_val;
    wb_en_i = n_wb_en; wb_addr_i = n_wb_addr; wb_data_i = n_wb_data;
    inst_i = inst; pc_i = pc; inst_valid_i = vld;
    stall_i = stl; branch_en_i = br;
    c = int'(inst[31:29]);
    legal = c < 6;
    rsv = c <= 3;
    rdi = inst[24:21];
    rsi = inst[20:17];
    use_rs = !inst[16] || c == 3 || c == 4;
    hz = blocked(rdi) || (use_rs && blocked(rsi));
    ready = !m_flush && !stl && !hz;
    @(negedge clk);
    chk("inst_ready", inst_ready_o, ready);
    acc = vld && ready && !br;
    if (e_valid && e_rsv && !stl && !br) begin
      n_wb_en = 1; n_wb_addr = e_rd;
      n_wb_data = (f_en && e_rd == f_rd) ? f_val : $urandom;
    end else n_wb_en = 0;
    rdv = rdreg(rdi);
    rsv_val = rdreg(rsi);
    if (wb_en_i) m_regs[wb_addr_i] = wb_data_i;
    if (br) foreach (m_pend[i]) m_pend[i] = 0;
    else begin
      if (wb_en_i) m_pend[wb_addr_i] = 0;
      if (acc && rsv && legal) m_pend[rdi] = 1;
    end
    m_flush = br;
    if (br || (!acc && !stl) || (acc && !legal)) begin
      e_valid = 0; e_ctrl = 0; e_rsv = 0;
    end else if (acc) begin
      e_valid = 1; e_rsv = rsv;
      e_ctrl = 6'b100000 >> c;
      e_rd = rdi; e_rdv = rdv; e_rsv_val = rsv_val;
      e_imm = {{16{inst[15]}}, inst[15:0]};
      e_pc = pc; e_opc = inst[31:25]; e_immf = inst[16];
    end
    @(posedge clk);
    #1;
    chk("valid", valid_o, e_valid);
    chk("ctrl", {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o,
                 ctrl_ld_o, ctrl_st_o, ctrl_br_o}, e_ctrl);
    chk("rsv", rsv_o, e_rsv);
    if (e_valid) begin
      chk("rd_value", rd_value_o, e_rdv);
      chk("rs_value", rs_value_o, e_rsv_val);
      chk("imm_value", imm_value_o, e_imm);
      chk("rd_addr", rd_addr_o, e_rd);
      chk("pc_value", pc_value_o, e_pc);
      chk("opcode", opcode_o, e_opc);
      chk("immf", immf_o, e_immf);
    end
  endtask

  initial begin
    bit acc;
    int n;
    logic [31:0] cur;
    logic [15:0] pc;
    foreach (m_regs[i]) begin m_regs[i] = 0; m_pend[i] = 0; end
    m_flush = 0; e_valid = 0; e_rsv = 0; e_ctrl = 0; e_immf = 0;
    e_rdv = 0; e_rsv_val = 0; e_imm = 0; e_rd = 0; e_pc = 0; e_opc = 0;
    n_wb_en = 0; n_wb_addr = 0; n_wb_data = 0;
    f_en = 0; f_rd = 0; f_val = 0;

    // Reset held with a valid instruction waiting
    rst = 0; inst_valid_i = 1; inst_i = 32'h0123_4567; pc_i = 16'h55;
    stall_i = 0; branch_en_i = 0;
    wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", inst_ready_o, 0);
    chk("rst_ctrl", {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o,
                     ctrl_ld_o, ctrl_st_o, ctrl_br_o}, 0);
    chk("rst_rsv", rsv_o, 0);
    chk("rst_rdv", rd_value_o, 0);
    chk("rst_rsv_val", rs_value_o, 0);
    chk("rst_imm", imm_value_o, 0);
    chk("rst_rd", rd_addr_o, 0);
    chk("rst_pc", pc_value_o, 0);
    chk("rst_opc", opcode_o, 0);
    chk("rst_immf", immf_o, 0);
    rst = 1;

    // Shift decode with sign-extended immediate
    cyc(mk(7'b0100000, 4'd3, 4'd0, 1'b1, 16'hFFF0), 16'h10, 1, 0, 0, acc);
    chk("shift_acc", acc, 1);
    chk("shift_ctrl", ctrl_shift_o, 1);
    chk("shift_imm", imm_value_o, 32'hFFFF_FFF0);
    chk("shift_rsv", rsv_o, 1);
    chk("shift_rd", rd_addr_o, 3);

    // RAW: inte rd=1, then inte rd=2 rs=1; r1 written with 5
    f_en = 1; f_rd = 1; f_val = 32'h5;
    cyc(mk(7'b0000000, 4'd1, 4'd0, 1'b1, 16'h1), 16'h14, 1, 0, 0, acc);
    chk("raw_prod_acc", acc, 1);
    n = 0;
    do begin
      cyc(mk(7'b0000000, 4'd2, 4'd1, 1'b0, 16'h0), 16'h18, 1, 0, 0, acc);
      if (!acc) n++;
    end while (!acc && n < 8);
    chk("raw_bubbles", n, FWD ? 1 : 2);
    chk("raw_rs_value", rs_value_o, 32'h5);
    f_en = 0;

    // Stall holds bundle for three cycles, next instruction not lost
    cyc(mk(7'b0010000, 4'd8, 4'd9, 1'b0, 16'h7), 16'h20, 1, 0, 0, acc);
    chk("stall_a_acc", acc, 1);
    repeat (3) begin
      cyc(mk(7'b0110000, 4'd10, 4'd11, 1'b1, 16'h8), 16'h24, 1, 1, 0, acc);
      chk("stall_pc_held", pc_value_o, 16'h20);
      chk("stall_acc", acc, 0);
    end
    cyc(mk(7'b0110000, 4'd10, 4'd11, 1'b1, 16'h8), 16'h24, 1, 0, 0, acc);
    chk("stall_b_acc", acc, 1);
    chk("stall_b_pc", pc_value_o, 16'h24);

    // Flush: pending r5 cleared, bubble, one FLUSH cycle
    cyc(mk(7'b0000000, 4'd5, 4'd0, 1'b1, 16'h0), 16'h30, 1, 0, 0, acc);
    cyc(mk(7'b1000000, 4'd6, 4'd5, 1'b0, 16'h0), 16'h34, 1, 1, 1, acc);
    chk("flush_valid", valid_o, 0);
    cyc(mk(7'b0000000, 4'd6, 4'd5, 1'b0, 16'h0), 16'h40, 1, 0, 0, acc);
    chk("flush_cycle_acc", acc, 0);
    cyc(mk(7'b0000000, 4'd6, 4'd5, 1'b0, 16'h0), 16'h40, 1, 0, 0, acc);
    chk("after_flush_acc", acc, 1);

    // Illegal opcode: bubble, no scoreboard entry for rd=7
    cyc(mk(7'b1110000, 4'd7, 4'd0, 1'b1, 16'h0), 16'h50, 1, 0, 0, acc);
    chk("illegal_acc", acc, 1);
    chk("illegal_valid", valid_o, 0);
    cyc(mk(7'b0010000, 4'd7, 4'd7, 1'b0, 16'h0), 16'h54, 1, 0, 0, acc);
    chk("illegal_dep_acc", acc, 1);

    // Random traffic
    pc = 16'h100;
    cur = mk(7'($urandom), 4'($urandom_range(0, 7)),
             4'($urandom_range(0, 7)), 1'($urandom), 16'($urandom));
    for (int k = 0; k < 400; k++) begin
      bit v, s, b;
      v = $urandom_range(0, 9) < 8;
      s = $urandom_range(0, 9) < 2;
      b = $urandom_range(0, 19) == 0;
      cyc(cur, pc, v, s, b, acc);
      if (acc || b) begin
        pc = pc + 16'd4;
        cur = mk(7'($urandom), 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 7)), 1'($urandom), 16'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
